alu_pipeline_reg: RTL and testbench
===================================

ALU_PIPELINE_REG -- requirements
Module: alu_pipeline_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 15, operand/result width in bits (>=1).
REQ-002 SHALL have parameter ALU_WIDTH, default 4, bits per pipeline chunk (>=1); CHUNK_COUNT = ceil(WIDTH/ALU_WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operation present on a/b/op/cin.
REQ-006 SHALL have port in_ready  output  1  operation accepted when in_valid && in_ready.
REQ-007 SHALL have port a  input  WIDTH  operand A, unsigned.
REQ-008 SHALL have port b  input  WIDTH  operand B, unsigned.
REQ-009 SHALL have port op  input  3  operation code, runtime-selectable per transaction.
REQ-010 SHALL have port cin  input  1  carry-in, used by ADD only.
REQ-011 SHALL have port out_valid  output  1  result present on sum/cout/flag.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result when out_valid && out_ready.
REQ-013 SHALL have port sum  output  WIDTH  arithmetic result.
REQ-014 SHALL have port cout  output  1  carry-out of most significant chunk.
REQ-015 SHALL have port flag  output  1  zero/compare flag per REQ-018.

Function
REQ-016 Op codes SHALL be: 0 ADD (a+b+cin), 1 SUB (a-b), 2 NOTEQ, 3 GE (a>=b unsigned), 4 INC (a+1), 5 DEC (a-1); codes 6,7 SHALL behave as ADD.
REQ-017 cout SHALL be: ADD/INC true carry out of bit WIDTH-1; SUB/GE/DEC 1 = no borrow (a>=b, a>=1); NOTEQ 0.
REQ-018 flag SHALL be: NOTEQ -> a!=b; GE -> a>=b; ADD/SUB/INC/DEC -> (sum==0); sum SHALL be 0 for NOTEQ and GE.
REQ-019 Chunk k (bits k*ALU_WIDTH upward; last chunk WIDTH-(CHUNK_COUNT-1)*ALU_WIDTH bits) SHALL be computed in pipeline stage k, carry and partial zero/inequality state registered between stages.
REQ-020 Operand chunk k SHALL be delayed k cycles (input skew); result chunk k SHALL be delayed CHUNK_COUNT-1-k cycles (output deskew) so all result bits of one transaction appear together.
REQ-021 Latency SHALL be exactly CHUNK_COUNT cycles from accept to out_valid with no backpressure; throughput one transaction per cycle.
REQ-022 op SHALL travel with its transaction through every stage; mixed ops back-to-back SHALL not interfere.
REQ-023 in_ready SHALL equal !(out_valid && !out_ready); when in_ready=0 the whole pipeline (data, carries, valid bits) SHALL hold.
REQ-024 Bubbles (in_valid=0) SHALL propagate as invalid stage bits; output registers SHALL keep last values while out_valid=0.
REQ-025 Results SHALL leave in acceptance order, none dropped or duplicated.
REQ-026 CHUNK_COUNT=1 SHALL give latency 1, no skew/deskew registers.
REQ-027 Wrap-around: sum SHALL be modulo 2^WIDTH (0x7FFF+1 -> 0 for WIDTH 15; 0-1 -> all ones, cout 0).

Reset
REQ-028 While rst=1, all stage valid bits, out_valid, sum, cout, flag SHALL be 0 on next edge; in_ready SHALL be 1.
REQ-029 rst mid-operation SHALL discard every in-flight transaction; no pre-reset result SHALL appear after release.
REQ-030 rst SHALL dominate in_valid and out_ready in the same cycle; skew data registers need not be reset.

Structure
REQ-031 Op codes and a CHUNK_COUNT/last-chunk-size function SHALL live in shared package alu_pipeline_pkg.
REQ-032 One chunk stage (chunk ALU plus carry/flag/valid registers) SHALL be sub-module alu_pipeline_stage, instantiated CHUNK_COUNT times by generate.
REQ-033 Arithmetic SHALL be expressible on the ripple-carry primitive chain per chunk; no multi-chunk combinational carry path.

Verification (WIDTH=15, ALU_WIDTH=4, CHUNK_COUNT=4 unless stated)
REQ-034 ADD a=0x7FFF b=0x0001 cin=0, out_ready=1 -> 4 cycles later sum=0x0000 cout=1 flag=1.
REQ-035 SUB a=5 b=7 -> sum=0x7FFE cout=0 flag=0; next cycle GE a=7 b=5 -> flag=1 cout=1 sum=0.
REQ-036 NOTEQ a=b=0x1234 -> flag=0; a=0x1234 b=0x5234 (top chunk only differs) -> flag=1.
REQ-037 32 random mixed ops back-to-back, out_ready random 50% -> outputs match golden model in order, in_ready low exactly when out_valid && !out_ready.
REQ-038 rst pulsed 1 cycle with 3 ops in flight -> next cycle out_valid=0 sum=0, in_ready=1; no old result ever emitted.
REQ-039 WIDTH=3 ALU_WIDTH=4: INC a=7 -> 1 cycle later sum=0 cout=1 flag=1; DEC a=0 -> sum=7 cout=0.

Source files
------------

// File: rtl/alu_pipeline_pkg.sv
// alu_pipeline_pkg
//   Shared definitions for the chunked ALU pipeline: operation codes, chunk
//   geometry helpers, the carry seed fed into chunk 0, and the functions that
//   turn the final chunk state into cout/flag.
package alu_pipeline_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_NOTEQ = 3'd2,
    OP_GE    = 3'd3,
    OP_INC   = 3'd4,
    OP_DEC   = 3'd5,
    OP_ADD6  = 3'd6,
    OP_ADD7  = 3'd7
  } op_e;

  function automatic int chunk_count(input int width, input int alu_width);
    return (width + alu_width - 1) / alu_width;
  endfunction

  function automatic int last_chunk_w(input int width, input int alu_width);
    return width - (chunk_count(width, alu_width) - 1) * alu_width;
  endfunction

  // Every op is an addition x + y + c; SUB/GE/INC need c=1 (two's complement
  // of b, or +1), DEC adds all-ones with c=0, ADD takes the external carry.
  function automatic logic carry_seed(input op_e op, input logic cin);
    logic c;
    case (op)
      OP_SUB, OP_GE, OP_INC: c = 1'b1;
      OP_DEC, OP_NOTEQ:      c = 1'b0;
      default:               c = cin;
    endcase
    return c;
  endfunction

  function automatic logic final_cout(input op_e op, input logic carry);
    return (op == OP_NOTEQ) ? 1'b0 : carry;
  endfunction

  // For GE the chained carry of a + ~b + 1 is exactly "no borrow", i.e. a>=b.
  function automatic logic final_flag(input op_e op, input logic carry,
                                      input logic zero, input logic ne);
    logic f;
    case (op)
      OP_NOTEQ: f = ne;
      OP_GE:    f = carry;
      default:  f = zero;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu_pipeline_stage.sv
// alu_pipeline_stage
//   One chunk of the pipelined ALU: a DATA_W-bit ripple adder on the chunk
//   operands plus the registers carrying valid, op, carry, running zero and
//   running inequality state into the next chunk.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     en            pipeline advance (low = hold everything)
//     vld_in/op_in  transaction valid and op arriving at this chunk
//     carry_in, zero_in, ne_in   chained state from the previous chunk
//     a_chunk, b_chunk           skewed operand chunk for this stage
//     vld_out..sum_out           registered state for the next chunk/output
module alu_pipeline_stage
  import alu_pipeline_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              vld_in,
  input  op_e               op_in,
  input  logic              carry_in,
  input  logic              zero_in,
  input  logic              ne_in,
  input  logic [DATA_W-1:0] a_chunk,
  input  logic [DATA_W-1:0] b_chunk,
  output logic              vld_out,
  output op_e               op_out,
  output logic              carry_out,
  output logic              zero_out,
  output logic              ne_out,
  output logic [DATA_W-1:0] sum_out
);

  logic [DATA_W-1:0] y;
  logic [DATA_W:0]   total;
  logic [DATA_W-1:0] sum_n;

  logic              vld_p0;
  op_e               op_p0;
  logic              carry_p0;
  logic              zero_p0;
  logic              ne_p0;
  logic [DATA_W-1:0] sum_p0;

  always_comb begin
    y = b_chunk;
    case (op_in)
      OP_SUB, OP_GE: y = ~b_chunk;
      OP_INC:        y = '0;
      OP_DEC:        y = '1;
      default:       y = b_chunk;
    endcase
    total = {1'b0, a_chunk} + {1'b0, y} + {{DATA_W{1'b0}}, carry_in};
    sum_n = total[DATA_W-1:0];
    if (op_in == OP_NOTEQ || op_in == OP_GE) begin
      sum_n = '0;
    end
  end

  // ---- stage register: chunk result and chained state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      op_p0    <= OP_ADD;
      carry_p0 <= 1'b0;
      zero_p0  <= 1'b0;
      ne_p0    <= 1'b0;
      sum_p0   <= '0;
    end else if (en) begin
      vld_p0 <= vld_in;
      // Bubbles leave the data untouched so the output holds its last value.
      if (vld_in) begin
        op_p0    <= op_in;
        carry_p0 <= total[DATA_W];
        zero_p0  <= zero_in && (sum_n == '0);
        ne_p0    <= ne_in || (a_chunk != b_chunk);
        sum_p0   <= sum_n;
      end
    end
  end

  assign vld_out   = vld_p0;
  assign op_out    = op_p0;
  assign carry_out = carry_p0;
  assign zero_out  = zero_p0;
  assign ne_out    = ne_p0;
  assign sum_out   = sum_p0;

endmodule

// File: rtl/alu_pipeline_reg.sv
// alu_pipeline_reg
//   Chunk-pipelined ALU (ADD, SUB, NOTEQ, GE, INC, DEC). Each ALU_WIDTH-bit
//   chunk is computed one cycle after the chunk below it; operands are skewed
//   on the way in and result chunks deskewed on the way out so a transaction
//   leaves whole, CHUNK_COUNT cycles after acceptance.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     in_valid/in_ready        input handshake (a, b, op, cin)
//     out_valid/out_ready      output handshake (sum, cout, flag)
//     a, b                     unsigned WIDTH-bit operands
//     op                       3-bit op code, cin carry-in for ADD
//     sum, cout, flag          result, carry/no-borrow, zero/compare flag
module alu_pipeline_reg
  import alu_pipeline_pkg::*;
#(
  parameter int WIDTH     = 15,
  parameter int ALU_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             flag
);

  localparam int CC     = chunk_count(WIDTH, ALU_WIDTH);
  localparam int LAST_W = last_chunk_w(WIDTH, ALU_WIDTH);

  logic          en;
  op_e           op_in;
  logic [CC-1:0] vld_s;
  logic [CC-1:0] carry_s;
  logic [CC-1:0] zero_s;
  logic [CC-1:0] ne_s;
  op_e           op_s [CC];

  // A stalled output freezes the whole pipeline, so one enable serves all.
  assign in_ready = !(out_valid && !out_ready);
  assign en       = in_ready;
  assign op_in    = op_e'(op);

  for (genvar k = 0; k < CC; k++) begin : g_chunk
    localparam int CW  = (k == CC - 1) ? LAST_W : ALU_WIDTH;
    localparam int LSB = k * ALU_WIDTH;
    localparam int DS  = CC - 1 - k;

    logic [CW-1:0] a_k;
    logic [CW-1:0] b_k;
    logic [CW-1:0] sum_k;
    logic          vld_i;
    logic          carry_i;
    logic          zero_i;
    logic          ne_i;
    op_e           op_i;

    if (k == 0) begin : g_head
      assign a_k     = a[LSB +: CW];
      assign b_k     = b[LSB +: CW];
      assign vld_i   = in_valid;
      assign op_i    = op_in;
      assign carry_i = carry_seed(op_in, cin);
      assign zero_i  = 1'b1;
      assign ne_i    = 1'b0;
    end else begin : g_body
      logic [CW-1:0] a_skew [k];
      logic [CW-1:0] b_skew [k];

      // ---- input skew: chunk k operands wait k cycles ----
      always_ff @(posedge clk) begin
        if (en) begin
          a_skew[0] <= a[LSB +: CW];
          b_skew[0] <= b[LSB +: CW];
          for (int j = 1; j < k; j++) begin
            a_skew[j] <= a_skew[j-1];
            b_skew[j] <= b_skew[j-1];
          end
        end
      end

      assign a_k     = a_skew[k-1];
      assign b_k     = b_skew[k-1];
      assign vld_i   = vld_s[k-1];
      assign op_i    = op_s[k-1];
      assign carry_i = carry_s[k-1];
      assign zero_i  = zero_s[k-1];
      assign ne_i    = ne_s[k-1];
    end

    alu_pipeline_stage #(
      .DATA_W (CW)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .vld_in    (vld_i),
      .op_in     (op_i),
      .carry_in  (carry_i),
      .zero_in   (zero_i),
      .ne_in     (ne_i),
      .a_chunk   (a_k),
      .b_chunk   (b_k),
      .vld_out   (vld_s[k]),
      .op_out    (op_s[k]),
      .carry_out (carry_s[k]),
      .zero_out  (zero_s[k]),
      .ne_out    (ne_s[k]),
      .sum_out   (sum_k)
    );

    if (DS == 0) begin : g_direct
      assign sum[LSB +: CW] = sum_k;
    end else begin : g_deskew
      logic [CW-1:0] sum_dsk [DS];

      // ---- output deskew: chunk k result waits CC-1-k cycles ----
      // Each slot loads only when the transaction beside it is valid, so the
      // visible result holds through bubbles.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < DS; j++) begin
            sum_dsk[j] <= '0;
          end
        end else if (en) begin
          if (vld_s[k]) begin
            sum_dsk[0] <= sum_k;
          end
          for (int j = 1; j < DS; j++) begin
            if (vld_s[k+j]) begin
              sum_dsk[j] <= sum_dsk[j-1];
            end
          end
        end
      end

      assign sum[LSB +: CW] = sum_dsk[DS-1];
    end
  end

  assign out_valid = vld_s[CC-1];
  assign cout      = final_cout(op_s[CC-1], carry_s[CC-1]);
  assign flag      = final_flag(op_s[CC-1], carry_s[CC-1], zero_s[CC-1], ne_s[CC-1]);

endmodule

// File: tb/tb_alu_pipeline_reg.sv
module tb_alu_pipeline_reg;

  typedef struct {
    logic [14:0] sum;
    logic        cout;
    logic        flag;
    int          acc;
    bit          lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] a;
  logic [14:0] b;
  logic [2:0]  op;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] sum;
  logic        cout;
  logic        flag;

  logic        iv3;
  logic        ir3;
  logic [2:0]  a3;
  logic [2:0]  b3;
  logic [2:0]  op3;
  logic        cin3;
  logic        ov3;
  logic        or3;
  logic [2:0]  sum3;
  logic        cout3;
  logic        flag3;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   mon_en   = 0;
  exp_t q[$];
  exp_t e_mon;

  alu_pipeline_reg #(.WIDTH(15), .ALU_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .flag(flag)
  );

  alu_pipeline_reg #(.WIDTH(3), .ALU_WIDTH(4)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3),
    .a(a3), .b(b3), .op(op3), .cin(cin3),
    .out_valid(ov3), .out_ready(or3),
    .sum(sum3), .cout(cout3), .flag(flag3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {flag, cout, sum} for a 15-bit transaction.
  function automatic logic [16:0] model(input logic [2:0] o, input logic [14:0] xa,
                                        input logic [14:0] xb, input logic xc);
    logic [15:0] r;
    logic [14:0] s;
    logic        co;
    logic        fl;
    r = '0; s = '0; co = 1'b0; fl = 1'b0;
    case (o)
      3'd1: begin s = xa - xb; co = (xa >= xb); fl = (s == 15'd0); end
      3'd2: begin s = '0; co = 1'b0; fl = (xa != xb); end
      3'd3: begin s = '0; co = (xa >= xb); fl = (xa >= xb); end
      3'd4: begin r = {1'b0, xa} + 16'd1; s = r[14:0]; co = r[15]; fl = (s == 15'd0); end
      3'd5: begin s = xa - 15'd1; co = (xa != 15'd0); fl = (s == 15'd0); end
      default: begin
        r = {1'b0, xa} + {1'b0, xb} + {15'd0, xc};
        s = r[14:0]; co = r[15]; fl = (s == 15'd0);
      end
    endcase
    return {fl, co, s};
  endfunction

  // Present one operation and hold it until accepted; the expectation is
  // queued at the negedge preceding the accepting edge.
  task automatic send(input logic [2:0] o, input logic [14:0] xa, input logic [14:0] xb,
                      input logic xc, input logic [14:0] es, input logic ec,
                      input logic ef, input bit lat, input bit rnd_ready);
    bit   done;
    exp_t e;
    done = 0;
    op = o; a = xa; b = xb; cin = xc; in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) begin
        e.sum = es; e.cout = ec; e.flag = ef; e.acc = cyc; e.lat = lat;
        q.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    chk("accept_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic send_rand();
    logic [2:0]  o;
    logic [14:0] xa;
    logic [14:0] xb;
    logic        xc;
    logic [16:0] m;
    o  = 3'($urandom_range(0, 7));
    xa = ($urandom_range(0, 3) == 0) ? 15'h7FFF : 15'($urandom);
    xb = ($urandom_range(0, 3) == 0) ? xa : 15'($urandom);
    xc = 1'($urandom_range(0, 1));
    m  = model(o, xa, xb, xc);
    send(o, xa, xb, xc, m[14:0], m[15], m[16], 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: pop and compare every result the DUT hands over.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      chk("in_ready_rule", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", {31'd0, out_valid}, 32'd0);
        end else begin
          e_mon = q.pop_front();
          chk("sum",  {17'd0, sum},  {17'd0, e_mon.sum});
          chk("cout", {31'd0, cout}, {31'd0, e_mon.cout});
          chk("flag", {31'd0, flag}, {31'd0, e_mon.flag});
          if (e_mon.lat) chk("latency", cyc - e_mon.acc, 32'd4);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; cin = 1'b0; out_ready = 1'b1;
    iv3 = 1'b0; a3 = '0; b3 = '0; op3 = '0; cin3 = 1'b0; or3 = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum",       {17'd0, sum},       32'd0);
    chk("rst_cout",      {31'd0, cout},      32'd0);
    chk("rst_flag",      {31'd0, flag},      32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_ov3",       {31'd0, ov3},       32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1;

    // Directed ops, back to back, no backpressure (latency checked)
    send(3'd0, 15'h7FFF, 15'h0001, 1'b0, 15'h0000, 1'b1, 1'b1, 1, 0);
    send(3'd1, 15'd5,    15'd7,    1'b0, 15'h7FFE, 1'b0, 1'b0, 1, 0);
    send(3'd3, 15'd7,    15'd5,    1'b0, 15'h0000, 1'b1, 1'b1, 1, 0);
    send(3'd2, 15'h1234, 15'h1234, 1'b0, 15'h0000, 1'b0, 1'b0, 1, 0);
    send(3'd2, 15'h1234, 15'h5234, 1'b0, 15'h0000, 1'b0, 1'b1, 1, 0);
    send(3'd2, 15'h1234, 15'h1235, 1'b0, 15'h0000, 1'b0, 1'b1, 1, 0);
    send(3'd4, 15'h7FFF, 15'h0000, 1'b0, 15'h0000, 1'b1, 1'b1, 1, 0);
    send(3'd5, 15'h0000, 15'h0000, 1'b0, 15'h7FFF, 1'b0, 1'b0, 1, 0);
    send(3'd6, 15'd1,    15'd2,    1'b1, 15'h0004, 1'b0, 1'b0, 1, 0);
    send(3'd7, 15'h7FFF, 15'h7FFF, 1'b1, 15'h7FFF, 1'b1, 1'b0, 1, 0);
    send(3'd0, 15'h0000, 15'h0000, 1'b1, 15'h0001, 1'b0, 1'b0, 1, 0);
    send(3'd3, 15'd4,    15'd9,    1'b0, 15'h0000, 1'b0, 1'b0, 1, 0);
    send(3'd1, 15'h0ABC, 15'h0ABC, 1'b0, 15'h0000, 1'b1, 1'b1, 1, 0);
    idle(8);
    chk("directed_drain", q.size(), 32'd0);

    // Random mixed ops with random backpressure and occasional bubbles
    for (int n = 0; n < 32; n++) begin
      send_rand();
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("random_drain", q.size(), 32'd0);

    // Reset with three operations in flight; an op offered during reset is dropped
    send(3'd0, 15'd10, 15'd20, 1'b0, 15'd30, 1'b0, 1'b0, 0, 0);
    send(3'd1, 15'd9,  15'd3,  1'b0, 15'd6,  1'b1, 1'b0, 0, 0);
    send(3'd4, 15'd1,  15'd0,  1'b0, 15'd2,  1'b0, 1'b0, 0, 0);
    rst = 1'b1; in_valid = 1'b1; op = 3'd0; a = 15'd1; b = 15'd1; cin = 1'b0;
    q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sum",       {17'd0, sum},       32'd0);
    chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    rst = 1'b0;
    in_valid = 1'b0;
    idle(10);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    // Single-chunk configuration: WIDTH=3, latency 1
    @(posedge clk);
    #1;
    iv3 = 1'b1; op3 = 3'd4; a3 = 3'd7; b3 = 3'd0;
    @(posedge clk);
    @(negedge clk);
    chk("w3_inc_valid", {31'd0, ov3},   32'd1);
    chk("w3_inc_sum",   {29'd0, sum3},  32'd0);
    chk("w3_inc_cout",  {31'd0, cout3}, 32'd1);
    chk("w3_inc_flag",  {31'd0, flag3}, 32'd1);
    op3 = 3'd5; a3 = 3'd0;
    @(posedge clk);
    @(negedge clk);
    chk("w3_dec_valid", {31'd0, ov3},   32'd1);
    chk("w3_dec_sum",   {29'd0, sum3},  32'd7);
    chk("w3_dec_cout",  {31'd0, cout3}, 32'd0);
    chk("w3_dec_flag",  {31'd0, flag3}, 32'd0);
    iv3 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("w3_bubble_valid", {31'd0, ov3},  32'd0);
    chk("w3_hold_sum",     {29'd0, sum3}, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
